reg_file: RTL and testbench

- Integer register file: 32 x XLEN, two read ports, one write port.
- Receiving end of the write-back interface. Consumes the data/destination/write-enable triple that the write-back stage produces, and serves operand reads to decode.
- Contains a pending-write scoreboard. Decode can stall on RAW hazards against instructions still in flight.

---
 rtl/instructions_pkg.sv | 17 +
 rtl/reg_file_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 49 ++++
 rtl/reg_file.sv | 80 ++++++++
 tb/tb_reg_file.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instructions_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instructions_pkg
//  Description : Shared widths and register-index type for the integer core.
//  Revision    : 1.0 - initial release
// ============================================================================
package instructions_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_if
//  Description : Write-back, operand-read and issue signals of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import instructions_pkg::*;
();

    xlen_t    wbData;
    reg_idx_t wbRd;
    logic     wbWriteEn;
    reg_idx_t rs1;
    reg_idx_t rs2;
    xlen_t    rs1Data;
    xlen_t    rs2Data;
    logic     issueValid;
    reg_idx_t issueRd;
    logic     flush;
    logic     stall;

    // Pipeline side: write-back stage and decode
    modport master (
        output wbData, wbRd, wbWriteEn, rs1, rs2, issueValid, issueRd, flush,
        input  rs1Data, rs2Data, stall
    );

    // Register file side
    modport slave (
        input  wbData, wbRd, wbWriteEn, rs1, rs2, issueValid, issueRd, flush,
        output rs1Data, rs2Data, stall
    );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Pending-write bit per architectural register for RAW detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import instructions_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rstn,
    input  wire logic                issueValid,
    input  wire reg_idx_t            issueRd,
    input  wire logic                wbWriteEn,
    input  wire reg_idx_t            wbRd,
    input  wire logic                flush,
    output      logic [NUM_REGS-1:0] pend
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    // Ordering gives set priority over clear, and flush priority over both
    always_comb begin
        pend_d = pend_q;
        if (wbWriteEn) begin
            pend_d[wbRd] = 1'b0;
        end
        if (issueValid && (issueRd != '0)) begin
            pend_d[issueRd] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32 x XLEN integer register file, 2R/1W, write-first bypass and
//                RAW stall from the pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import instructions_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rstn,
    reg_file_if.slave     bus
);

    xlen_t               regs_q [NUM_REGS];
    xlen_t               regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] w_pend;
    logic                w_byp1;
    logic                w_byp2;
    xlen_t               w_rs1_data;
    xlen_t               w_rs2_data;
    logic                w_stall;

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .issueValid (bus.issueValid),
        .issueRd    (bus.issueRd),
        .wbWriteEn  (bus.wbWriteEn),
        .wbRd       (bus.wbRd),
        .flush      (bus.flush),
        .pend       (w_pend)
    );

    always_comb begin
        regs_d = regs_q;
        if (bus.wbWriteEn && (bus.wbRd != '0)) begin
            regs_d[bus.wbRd] = bus.wbData;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Outputs are forced to zero while rstn is low so a same-cycle bypass cannot leak
    always_comb begin
        w_byp1     = bus.wbWriteEn && (bus.wbRd == bus.rs1) && (bus.rs1 != '0);
        w_byp2     = bus.wbWriteEn && (bus.wbRd == bus.rs2) && (bus.rs2 != '0);
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_stall    = 1'b0;
        if (rstn) begin
            if (w_byp1) begin
                w_rs1_data = bus.wbData;
            end else if (bus.rs1 != '0) begin
                w_rs1_data = regs_q[bus.rs1];
            end
            if (w_byp2) begin
                w_rs2_data = bus.wbData;
            end else if (bus.rs2 != '0) begin
                w_rs2_data = regs_q[bus.rs2];
            end
            w_stall = (w_pend[bus.rs1] && !w_byp1) || (w_pend[bus.rs2] && !w_byp2);
        end
    end

    assign bus.rs1Data = w_rs1_data;
    assign bus.rs2Data = w_rs2_data;
    assign bus.stall   = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed self-checking bench for reg_file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    reg_file_if bus ();

    reg_file dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%h with no queued expectation", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.wbData     = '0;
        bus.wbRd       = '0;
        bus.wbWriteEn  = 1'b0;
        bus.issueValid = 1'b0;
        bus.issueRd    = '0;
        bus.flush      = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.rs1 = '0;
        bus.rs2 = '0;

        // Reset state
        #1;
        expect_val(32'h0); expect_val(32'h0); expect_val(32'h0);
        check("reset_rs1", bus.rs1Data);
        check("reset_rs2", bus.rs2Data);
        check("reset_stall", {31'b0, bus.stall});
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Basic write/read
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd3; bus.wbData = 32'h12345678;
        tick();
        idle_inputs();
        bus.rs1 = 5'd3; bus.rs2 = 5'd3;
        expect_val(32'h12345678); expect_val(32'h12345678);
        #1;
        check("wr_rd_rs1", bus.rs1Data);
        check("wr_rd_rs2", bus.rs2Data);

        // x0 immunity: write and issue to x0
        bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd0; bus.wbData = 32'hFFFFFFFF;
        bus.issueValid = 1'b1; bus.issueRd = 5'd0;
        expect_val(32'h0); expect_val(32'h0);
        #1;
        check("x0_same_cycle", bus.rs1Data);
        check("x0_stall_same", {31'b0, bus.stall});
        tick();
        idle_inputs();
        expect_val(32'h0); expect_val(32'h0);
        #1;
        check("x0_after", bus.rs1Data);
        check("x0_no_pend", {31'b0, bus.stall});

        // Bypass on read port B
        bus.rs2 = 5'd7;
        expect_val(32'h0);
        #1;
        check("x7_before", bus.rs2Data);
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd7; bus.wbData = 32'hA5A5A5A5;
        expect_val(32'hA5A5A5A5); expect_val(32'h0);
        #1;
        check("bypass_rs2", bus.rs2Data);
        check("bypass_rs1_unrelated", bus.rs1Data);
        tick();
        idle_inputs();
        expect_val(32'hA5A5A5A5);
        #1;
        check("x7_after", bus.rs2Data);

        // Hazard stall on x9
        bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.issueValid = 1'b1; bus.issueRd = 5'd9;
        tick();
        idle_inputs();
        bus.rs1 = 5'd9;
        expect_val(32'h1);
        #1;
        check("hazard_stall_1", {31'b0, bus.stall});
        tick();
        expect_val(32'h1);
        check("hazard_stall_2", {31'b0, bus.stall});
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd9; bus.wbData = 32'hCAFEF00D;
        expect_val(32'h0); expect_val(32'hCAFEF00D);
        #1;
        check("hazard_wb_stall", {31'b0, bus.stall});
        check("hazard_wb_data", bus.rs1Data);
        tick();
        idle_inputs();
        expect_val(32'h0); expect_val(32'hCAFEF00D);
        #1;
        check("hazard_after_stall", {31'b0, bus.stall});
        check("hazard_after_data", bus.rs1Data);

        // Set/clear collision on x4: set wins
        bus.rs1 = 5'd0;
        bus.issueValid = 1'b1; bus.issueRd = 5'd4;
        tick();
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd4; bus.wbData = 32'h00000044;
        tick();
        idle_inputs();
        bus.rs1 = 5'd4;
        expect_val(32'h1); expect_val(32'h00000044);
        #1;
        check("collision_stall", {31'b0, bus.stall});
        check("collision_data", bus.rs1Data);

        // Flush clears pending at the edge, not before
        bus.flush = 1'b1;
        expect_val(32'h1);
        #1;
        check("flush_pre_edge", {31'b0, bus.stall});
        tick();
        idle_inputs();
        expect_val(32'h0);
        #1;
        check("flush_post_edge", {31'b0, bus.stall});

        // Flush overrides same-cycle issue; write-back still lands
        bus.rs1 = 5'd0;
        bus.flush = 1'b1; bus.issueValid = 1'b1; bus.issueRd = 5'd6;
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd6; bus.wbData = 32'h66666666;
        tick();
        idle_inputs();
        bus.rs1 = 5'd6;
        expect_val(32'h0); expect_val(32'h66666666);
        #1;
        check("flush_vs_issue", {31'b0, bus.stall});
        check("flush_wb_lands", bus.rs1Data);

        // Reset mid-run after writing x5 and leaving it pending
        bus.rs1 = 5'd0;
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd5; bus.wbData = 32'hDEADBEEF;
        tick();
        idle_inputs();
        bus.issueValid = 1'b1; bus.issueRd = 5'd5;
        tick();
        idle_inputs();
        bus.rs1 = 5'd5;
        expect_val(32'hDEADBEEF); expect_val(32'h1);
        #1;
        check("x5_before_reset", bus.rs1Data);
        check("x5_pending", {31'b0, bus.stall});
        rstn = 1'b0;
        bus.wbWriteEn = 1'b1; bus.wbRd = 5'd5; bus.wbData = 32'h11111111;
        expect_val(32'h0); expect_val(32'h0);
        #1;
        check("in_reset_rs1", bus.rs1Data);
        check("in_reset_stall", {31'b0, bus.stall});
        tick();
        idle_inputs();
        rstn = 1'b1;
        expect_val(32'h0); expect_val(32'h0);
        #1;
        check("after_reset_rs1", bus.rs1Data);
        check("after_reset_stall", {31'b0, bus.stall});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
